// File: rtl/bpred_table_sched.sv
`default_nettype none
// ============================================================================
// Module      : bpred_table_sched
// Description : Arbitrates a single-port 2-bit counter table between fetch
//               lookups and buffered branch-resolution read-modify-writes,
//               runs the post-reset clear sweep and keeps hit/miss counts.
// Revision    : 1.0 - initial release
// ============================================================================
module bpred_table_sched #(
    parameter int         N        = 32,
    parameter int         IDX_W    = 10,
    parameter int         DEPTH    = 4,
    parameter logic [1:0] INIT_VAL = 2'b00
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             lk_valid,
    input  logic [N-1:0]     lk_pc,
    output logic             lk_ready,
    output logic             pred_valid,
    output logic             pred_taken,
    input  logic             rs_valid,
    input  logic [N-1:0]     rs_pc,
    input  logic             rs_taken,
    input  logic             rs_pred,
    output logic             rs_ready,
    output logic             tbl_en,
    output logic             tbl_we,
    output logic [IDX_W-1:0] tbl_addr,
    output logic [1:0]       tbl_wdata,
    input  logic [1:0]       tbl_rdata,
    output logic             busy,
    output logic [N-1:0]     hit_cnt,
    output logic [N-1:0]     miss_cnt
);

    localparam int                 c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);
    localparam int                 c_ENT_W = IDX_W + 2;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_UPD_RD = 2'd2,
        ST_UPD_WR = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_sweep;
    logic [c_ENT_W-1:0] r_fifo [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [N-1:0]       r_hit_cnt;
    logic [N-1:0]       r_miss_cnt;
    logic               r_pred_valid;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_accept;
    logic               w_lk_ready;
    logic               w_rs_ready;
    logic               w_tbl_en;
    logic               w_tbl_we;
    logic [IDX_W-1:0]   w_tbl_addr;
    logic [1:0]         w_tbl_wdata;
    logic [1:0]         w_sat;
    logic [c_ENT_W-1:0] w_head;
    logic [IDX_W-1:0]   w_head_idx;
    logic               w_head_taken;
    logic               w_head_hit;
    logic               w_unused;

    // FIFO entry: {index, outcome, prediction-was-correct}
    assign w_head       = r_fifo[r_rd_ptr];
    assign w_head_idx   = w_head[c_ENT_W-1:2];
    assign w_head_taken = w_head[1];
    assign w_head_hit   = w_head[0];
    assign w_full       = (r_count == c_FULL);
    assign w_empty      = (r_count == '0);
    assign w_push       = rs_valid && w_rs_ready;
    assign w_unused     = ^{lk_pc, rs_pc};

    always_comb begin
        w_sat = tbl_rdata;
        if (w_head_taken) begin
            if (tbl_rdata != 2'b11) w_sat = tbl_rdata + 2'd1;
        end else begin
            if (tbl_rdata != 2'b00) w_sat = tbl_rdata - 2'd1;
        end
    end

    // Reset gates every request/handshake output so nothing leaks while held.
    always_comb begin
        w_state_next = r_state;
        w_tbl_en     = 1'b0;
        w_tbl_we     = 1'b0;
        w_tbl_addr   = '0;
        w_tbl_wdata  = 2'b00;
        w_lk_ready   = 1'b0;
        w_rs_ready   = 1'b0;
        w_pop        = 1'b0;
        w_accept     = 1'b0;
        if (!reset) begin
            w_rs_ready = !w_full && (r_state != ST_INIT);
            case (r_state)
                ST_INIT: begin
                    w_tbl_en    = 1'b1;
                    w_tbl_we    = 1'b1;
                    w_tbl_addr  = r_sweep;
                    w_tbl_wdata = INIT_VAL;
                    if (r_sweep == {IDX_W{1'b1}}) w_state_next = ST_IDLE;
                end
                ST_IDLE: begin
                    w_lk_ready = !w_full;
                    if (w_full) begin
                        w_state_next = ST_UPD_RD;
                    end else if (lk_valid) begin
                        w_accept   = 1'b1;
                        w_tbl_en   = 1'b1;
                        w_tbl_addr = lk_pc[IDX_W+1:2];
                    end else if (!w_empty) begin
                        w_state_next = ST_UPD_RD;
                    end
                end
                ST_UPD_RD: begin
                    w_tbl_en     = 1'b1;
                    w_tbl_addr   = w_head_idx;
                    w_state_next = ST_UPD_WR;
                end
                ST_UPD_WR: begin
                    w_tbl_en     = 1'b1;
                    w_tbl_we     = 1'b1;
                    w_tbl_addr   = w_head_idx;
                    w_tbl_wdata  = w_sat;
                    w_pop        = 1'b1;
                    w_state_next = ST_IDLE;
                end
                default: w_state_next = ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_INIT;
            r_sweep      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
            r_pred_valid <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pred_valid <= w_accept;
            if (r_state == ST_INIT) r_sweep <= r_sweep + 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_pop) begin
                if (w_head_hit) begin
                    if (r_hit_cnt != {N{1'b1}}) r_hit_cnt <= r_hit_cnt + 1'b1;
                end else begin
                    if (r_miss_cnt != {N{1'b1}}) r_miss_cnt <= r_miss_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_fifo[r_wr_ptr] <= {rs_pc[IDX_W+1:2], rs_taken, rs_pred == rs_taken};
    end

    assign lk_ready   = w_lk_ready;
    assign rs_ready   = w_rs_ready;
    assign tbl_en     = w_tbl_en;
    assign tbl_we     = w_tbl_we;
    assign tbl_addr   = w_tbl_addr;
    assign tbl_wdata  = w_tbl_wdata;
    assign pred_valid = r_pred_valid;
    assign pred_taken = r_pred_valid & tbl_rdata[1];
    assign busy       = reset || (r_state == ST_INIT);
    assign hit_cnt    = r_hit_cnt;
    assign miss_cnt   = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bpred_table_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_bpred_table_sched
// Description : Directed + randomized bench for bpred_table_sched with a
//               queue/array reference model of the scheduling rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bpred_table_sched;

    localparam int         N        = 8;
    localparam int         IDX_W    = 4;
    localparam int         DEPTH    = 4;
    localparam logic [1:0] INIT_VAL = 2'b00;
    localparam int         ENTRIES  = 1 << IDX_W;
    localparam longint     CNT_MAX  = (1 << N) - 1;

    logic             clock = 1'b0;
    logic             reset;
    logic             lk_valid, rs_valid, rs_taken, rs_pred;
    logic [N-1:0]     lk_pc, rs_pc;
    logic             lk_ready, pred_valid, pred_taken, rs_ready;
    logic             tbl_en, tbl_we, busy;
    logic [IDX_W-1:0] tbl_addr;
    logic [1:0]       tbl_wdata;
    logic [1:0]       tbl_rdata = 2'b00;
    logic [N-1:0]     hit_cnt, miss_cnt;

    bpred_table_sched #(.N(N), .IDX_W(IDX_W), .DEPTH(DEPTH), .INIT_VAL(INIT_VAL)) dut (
        .clock(clock), .reset(reset),
        .lk_valid(lk_valid), .lk_pc(lk_pc), .lk_ready(lk_ready),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .rs_valid(rs_valid), .rs_pc(rs_pc), .rs_taken(rs_taken), .rs_pred(rs_pred),
        .rs_ready(rs_ready),
        .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
        .tbl_wdata(tbl_wdata), .tbl_rdata(tbl_rdata),
        .busy(busy), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clock = ~clock;

    // Single-port table memory seen by the scheduler
    logic [1:0] mem [ENTRIES];
    initial for (int i = 0; i < ENTRIES; i++) mem[i] = 2'($urandom_range(0, 3));
    always @(posedge clock) begin
        if (tbl_en) begin
            if (tbl_we) mem[tbl_addr] <= tbl_wdata;
            else        tbl_rdata     <= mem[tbl_addr];
        end
    end

    // Reference model: mode 0=clearing, 1=idle, 2=update read, 3=update write
    typedef struct {int idx; bit taken; bit hit;} ent_t;
    ent_t   q[$];
    int     tbl [ENTRIES];
    int     m_mode = 0;
    int     m_sweep = 0;
    longint m_hit = 0, m_miss = 0;
    bit     m_pv = 0, m_pt = 0;

    int ncmp = 0, nfail = 0;
    bit e_busy, e_lkr, e_rsr, e_en, e_we;
    int e_addr, e_wd;

    function automatic int pc_idx(input logic [N-1:0] pc);
        return (int'(pc) / 4) % ENTRIES;
    endfunction

    function automatic int sat(input int c, input bit taken);
        if (taken) return (c + 1 > 3) ? 3 : c + 1;
        return (c - 1 < 0) ? 0 : c - 1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compute_expect();
        e_busy = 1; e_lkr = 0; e_rsr = 0; e_en = 0; e_we = 0; e_addr = 0; e_wd = 0;
        if (!reset) begin
            e_busy = (m_mode == 0);
            e_lkr  = (m_mode == 1) && (q.size() < DEPTH);
            e_rsr  = (m_mode != 0) && (q.size() < DEPTH);
            case (m_mode)
                0: begin e_en = 1; e_we = 1; e_addr = m_sweep; e_wd = int'(INIT_VAL); end
                1: if (lk_valid && e_lkr) begin e_en = 1; e_addr = pc_idx(lk_pc); end
                2: begin e_en = 1; e_addr = q[0].idx; end
                3: begin e_en = 1; e_we = 1; e_addr = q[0].idx; e_wd = sat(tbl[q[0].idx], q[0].taken); end
                default: ;
            endcase
        end
    endtask

    task automatic check_outputs();
        compute_expect();
        chk("busy", 64'(busy), 64'(e_busy));
        chk("lk_ready", 64'(lk_ready), 64'(e_lkr));
        chk("rs_ready", 64'(rs_ready), 64'(e_rsr));
        chk("tbl_en", 64'(tbl_en), 64'(e_en));
        if (e_en) begin
            chk("tbl_we", 64'(tbl_we), 64'(e_we));
            chk("tbl_addr", 64'(tbl_addr), 64'(e_addr));
            if (e_we) chk("tbl_wdata", 64'(tbl_wdata), 64'(e_wd));
        end
        chk("pred_valid", 64'(pred_valid), 64'(m_pv));
        chk("pred_taken", 64'(pred_taken), 64'(m_pv & m_pt));
        chk("hit_cnt", 64'(hit_cnt), 64'(m_hit));
        chk("miss_cnt", 64'(miss_cnt), 64'(m_miss));
    endtask

    task automatic model_step();
        bit   accept, push;
        ent_t e;
        compute_expect();
        if (reset) begin
            m_mode = 0; m_sweep = 0; q.delete(); m_hit = 0; m_miss = 0; m_pv = 0;
            return;
        end
        accept = (m_mode == 1) && lk_valid && e_lkr;
        push   = rs_valid && e_rsr;
        if (accept) m_pt = tbl[pc_idx(lk_pc)] >= 2;
        case (m_mode)
            0: begin
                tbl[m_sweep] = int'(INIT_VAL);
                if (m_sweep == ENTRIES - 1) m_mode = 1;
                m_sweep = (m_sweep + 1) % ENTRIES;
            end
            1: begin
                if (q.size() == DEPTH) m_mode = 2;
                else if (!lk_valid && q.size() > 0) m_mode = 2;
            end
            2: m_mode = 3;
            3: begin
                tbl[q[0].idx] = sat(tbl[q[0].idx], q[0].taken);
                if (q[0].hit) m_hit  = (m_hit  < CNT_MAX) ? m_hit  + 1 : CNT_MAX;
                else          m_miss = (m_miss < CNT_MAX) ? m_miss + 1 : CNT_MAX;
                void'(q.pop_front());
                m_mode = 1;
            end
            default: ;
        endcase
        m_pv = accept;
        if (push) begin
            e.idx = pc_idx(rs_pc); e.taken = rs_taken; e.hit = (rs_taken == rs_pred);
            q.push_back(e);
        end
    endtask

    task automatic cycle();
        @(negedge clock);
        check_outputs();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic drive(input bit lv, input int lpc, input bit rv, input int rpc,
                         input bit rt, input bit rp);
        lk_valid = lv; lk_pc = N'(lpc);
        rs_valid = rv; rs_pc = N'(rpc); rs_taken = rt; rs_pred = rp;
    endtask

    task automatic drive_random(input int lk_pct, input int rs_pct);
        drive($urandom_range(0, 99) < lk_pct, $urandom, $urandom_range(0, 99) < rs_pct,
              $urandom, $urandom_range(0, 1), $urandom_range(0, 1));
    endtask

    initial begin
        bit reached;
        for (int i = 0; i < ENTRIES; i++) tbl[i] = 0;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) cycle();

        // Clear sweep, then idle with lookups allowed
        reset = 1'b0;
        repeat (ENTRIES) cycle();
        cycle();
        chk("t1_busy_low", 64'(busy), 64'd0);
        chk("t1_lk_ready", 64'(lk_ready), 64'd1);

        // Lookup after clear
        drive(1, 'h40, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0);
        cycle();

        // Four taken resolutions mispredicted as not-taken on one index
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 'h8, 1, 0);
            cycle();
        end
        drive(0, 0, 0, 0, 0, 0);
        repeat (12) cycle();
        chk("t3_miss_cnt", 64'(miss_cnt), 64'd4);
        drive(1, 'h8, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("t3_pred_taken", 64'(pred_taken), 64'd1);
        cycle();

        // Lookups held high while the FIFO fills
        for (int i = 0; i < 24; i++) begin
            drive(1, $urandom, i < 6, $urandom, $urandom_range(0, 1), $urandom_range(0, 1));
            cycle();
        end
        drive(0, 0, 0, 0, 0, 0);
        repeat (12) cycle();

        // Correct not-taken at a cleared counter, then drive hit_cnt to saturation
        drive(0, 0, 1, 'h10, 0, 0);
        cycle();
        for (int i = 0; i < 900; i++) begin
            drive(0, 0, 1, $urandom, 1, 1);
            cycle();
        end
        drive(0, 0, 0, 0, 0, 0);
        repeat (12) cycle();
        chk("t5_hit_sat", 64'(hit_cnt), 64'(CNT_MAX));

        // Random mix
        for (int i = 0; i < 600; i++) begin
            drive_random(50, 45);
            cycle();
        end

        // Reset during an update write with several resolutions queued
        reached = 0;
        for (int i = 0; i < 50 && !reached; i++) begin
            drive(0, 0, 1, $urandom, $urandom_range(0, 1), $urandom_range(0, 1));
            if (m_mode == 3 && q.size() >= 3) reached = 1;
            else cycle();
        end
        chk("t6_reached_upd_wr", 64'(reached), 64'd1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        chk("t6_hit_zero", 64'(hit_cnt), 64'd0);
        chk("t6_miss_zero", 64'(miss_cnt), 64'd0);
        chk("t6_sweep_addr0", 64'(tbl_addr), 64'd0);
        repeat (ENTRIES + 2) cycle();

        for (int i = 0; i < 300; i++) begin
            drive_random(60, 40);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
`default_nettype wire
